// File: rtl/neuron_tdm_sched.sv
// Time-division-multiplexed sequencer: streams per-neuron state and currents through one LIF PU,
// writes results back and queues spike events. Define NEURON_TDM_SCHED_SPKCNT_EN to add o_spk_count.
module neuron_tdm_sched #(
   parameter int NUM_NEURONS    = 64,
   parameter int VMEM_WIDTH     = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int REF_WIDTH      = 3,
   parameter int V_RESET        = 0,
   parameter int TS_WIDTH       = 16,
   parameter int SPK_FIFO_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_step_start,
   output logic                           o_busy,
   output logic                           o_step_done,
   output logic [TS_WIDTH-1:0]            o_timestep,
   input  logic                           i_cur_valid,
   output logic                           o_cur_ready,
   input  logic [DATA_WIDTH-1:0]          i_cur_data,
   output logic                           o_pu_valid,
   output logic [VMEM_WIDTH-1:0]          o_pu_vmem,
   output logic [REF_WIDTH-1:0]           o_pu_ref_ctr,
   output logic [DATA_WIDTH-1:0]          o_pu_syn,
   input  logic                           i_pu_spike,
   input  logic [VMEM_WIDTH-1:0]          i_pu_vmem,
   input  logic [REF_WIDTH-1:0]           i_pu_ref_ctr,
   output logic                           o_spk_valid,
   input  logic                           i_spk_ready,
   output logic [$clog2(NUM_NEURONS)-1:0] o_spk_id,
   output logic [TS_WIDTH-1:0]            o_spk_ts
`ifdef NEURON_TDM_SCHED_SPKCNT_EN
   ,
   output logic [$clog2(NUM_NEURONS):0]   o_spk_count
`endif
);

   localparam int IDX_W = $clog2(NUM_NEURONS);
   localparam int FA_W  = $clog2(SPK_FIFO_DEPTH);
   localparam int FC_W  = FA_W + 1;
   localparam int FR_W  = FC_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t               state_r, state_s;
   logic [IDX_W-1:0]     idx_r, idx_s;
   logic [IDX_W-1:0]     wb_idx_r;
   logic                 wb_valid_r;
   logic [TS_WIDTH-1:0]  ts_r;
   logic                 step_done_r;
   logic                 issue_s, done_s, start_s, room_s, push_s, pop_s;

   logic [VMEM_WIDTH-1:0] vmem_mem_r [NUM_NEURONS];
   logic [REF_WIDTH-1:0]  ref_mem_r  [NUM_NEURONS];
   logic                  mem_we_s;
   logic [IDX_W-1:0]      mem_addr_s;
   logic [VMEM_WIDTH-1:0] mem_vmem_s;
   logic [REF_WIDTH-1:0]  mem_ref_s;

   logic [IDX_W-1:0]     fifo_id_r [SPK_FIFO_DEPTH];
   logic [TS_WIDTH-1:0]  fifo_ts_r [SPK_FIFO_DEPTH];
   logic [FA_W-1:0]      wr_ptr_r, rd_ptr_r;
   logic [FC_W-1:0]      count_r;

   // Issue is throttled so every in-flight writeback already owns a free FIFO slot.
   assign room_s = ({1'b0, count_r} + FR_W'(wb_valid_r)) < FR_W'(SPK_FIFO_DEPTH);
   assign push_s = wb_valid_r && i_pu_spike;
   assign pop_s  = (count_r != {FC_W{1'b0}}) && i_spk_ready;

   // Next-state and issue decision
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      issue_s = 1'b0;
      done_s  = 1'b0;
      start_s = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            if (idx_r == LAST_IDX) begin
               state_s = ST_IDLE;
               idx_s   = IDX_ZERO;
            end else begin
               idx_s = idx_r + IDX_W'(1);
            end
         end
         ST_IDLE: begin
            if (i_step_start) begin
               start_s = 1'b1;
               idx_s   = IDX_ZERO;
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (i_cur_valid && room_s) begin
               issue_s = 1'b1;
               if (idx_r == LAST_IDX) begin
                  idx_s   = IDX_ZERO;
                  state_s = ST_DRAIN;
               end else begin
                  idx_s = idx_r + IDX_W'(1);
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // The last issue always leaves exactly one writeback pending here.
            done_s  = 1'b1;
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_CLEAR;
            idx_s   = IDX_ZERO;
         end
      endcase
   end

   // Control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_CLEAR;
         idx_r       <= IDX_ZERO;
         wb_idx_r    <= IDX_ZERO;
         wb_valid_r  <= 1'b0;
         ts_r        <= {TS_WIDTH{1'b0}};
         step_done_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         idx_r       <= idx_s;
         wb_valid_r  <= issue_s;
         step_done_r <= done_s;
         if (issue_s) begin
            wb_idx_r <= idx_r;
         end
         if (done_s) begin
            ts_r <= ts_r + TS_WIDTH'(1);
         end
      end
   end

   // State memory write port: clear sweep or PU writeback
   always_comb begin
      mem_we_s   = 1'b0;
      mem_addr_s = wb_idx_r;
      mem_vmem_s = i_pu_vmem;
      mem_ref_s  = i_pu_ref_ctr;
      if (state_r == ST_CLEAR) begin
         mem_we_s   = 1'b1;
         mem_addr_s = idx_r;
         mem_vmem_s = VMEM_WIDTH'(V_RESET);
         mem_ref_s  = {REF_WIDTH{1'b0}};
      end else if (wb_valid_r) begin
         mem_we_s = 1'b1;
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // State memory storage (not reset; initialised by the clear sweep)
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         vmem_mem_r[mem_addr_s] <= mem_vmem_s;
         ref_mem_r[mem_addr_s]  <= mem_ref_s;
      end
   end

   // Spike FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {FA_W{1'b0}};
         rd_ptr_r <= {FA_W{1'b0}};
         count_r  <= {FC_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + FA_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + FA_W'(1);
         end
         count_r <= count_r + FC_W'(push_s) - FC_W'(pop_s);
      end
   end

   // Spike FIFO storage; entries carry the timestep they were produced in
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_id_r[wr_ptr_r] <= wb_idx_r;
         fifo_ts_r[wr_ptr_r] <= ts_r;
      end
   end

   // PU issue outputs
   always_comb begin
      o_cur_ready = issue_s;
      o_pu_valid  = issue_s;
      if (issue_s) begin
         o_pu_vmem    = vmem_mem_r[idx_r];
         o_pu_ref_ctr = ref_mem_r[idx_r];
         o_pu_syn     = i_cur_data;
      end else begin
         o_pu_vmem    = {VMEM_WIDTH{1'b0}};
         o_pu_ref_ctr = {REF_WIDTH{1'b0}};
         o_pu_syn     = {DATA_WIDTH{1'b0}};
      end
   end

   // Spike stream head
   always_comb begin
      if (count_r != {FC_W{1'b0}}) begin
         o_spk_valid = 1'b1;
         o_spk_id    = fifo_id_r[rd_ptr_r];
         o_spk_ts    = fifo_ts_r[rd_ptr_r];
      end else begin
         o_spk_valid = 1'b0;
         o_spk_id    = IDX_ZERO;
         o_spk_ts    = {TS_WIDTH{1'b0}};
      end
   end

   assign o_busy      = (state_r != ST_IDLE);
   assign o_step_done = step_done_r;
   assign o_timestep  = ts_r;

`ifdef NEURON_TDM_SCHED_SPKCNT_EN
   localparam int CNT_W = IDX_W + 1;
   logic [CNT_W-1:0] spk_cnt_r;
   logic [CNT_W-1:0] spk_count_r;

   // Per-step spike counter, latched together with the step-done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spk_cnt_r   <= {CNT_W{1'b0}};
         spk_count_r <= {CNT_W{1'b0}};
      end else begin
         if (start_s) begin
            spk_cnt_r <= {CNT_W{1'b0}};
         end else if (push_s) begin
            spk_cnt_r <= spk_cnt_r + CNT_W'(1);
         end else begin
            spk_cnt_r <= spk_cnt_r;
         end
         if (done_s) begin
            spk_count_r <= spk_cnt_r + CNT_W'(push_s);
         end
      end
   end

   assign o_spk_count = spk_count_r;
`endif

endmodule

// File: tb/tb_neuron_tdm_sched.sv
// Randomised bench for neuron_tdm_sched: behavioural LIF PU plus a per-step array model of all neurons.
module tb_neuron_tdm_sched;

   localparam int N      = 64;
   localparam int IW     = $clog2(N);
   localparam int THRESH = 120;
   localparam int LEAK   = 2;
   localparam int REFP   = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_step_start = 1'b0;
   logic          o_busy, o_step_done;
   logic [15:0]   o_timestep;
   logic          i_cur_valid = 1'b0;
   logic          o_cur_ready;
   logic [7:0]    i_cur_data = 8'd0;
   logic          o_pu_valid;
   logic [15:0]   o_pu_vmem;
   logic [2:0]    o_pu_ref_ctr;
   logic [7:0]    o_pu_syn;
   logic          i_pu_spike;
   logic [15:0]   i_pu_vmem;
   logic [2:0]    i_pu_ref_ctr;
   logic          o_spk_valid;
   logic          i_spk_ready = 1'b0;
   logic [IW-1:0] o_spk_id;
   logic [15:0]   o_spk_ts;
`ifdef NEURON_TDM_SCHED_SPKCNT_EN
   logic [IW:0]   o_spk_count;
`endif

   always #5 clk = ~clk;

   neuron_tdm_sched dut (
      .clk(clk), .rst_n(rst_n),
      .i_step_start(i_step_start), .o_busy(o_busy), .o_step_done(o_step_done), .o_timestep(o_timestep),
      .i_cur_valid(i_cur_valid), .o_cur_ready(o_cur_ready), .i_cur_data(i_cur_data),
      .o_pu_valid(o_pu_valid), .o_pu_vmem(o_pu_vmem), .o_pu_ref_ctr(o_pu_ref_ctr), .o_pu_syn(o_pu_syn),
      .i_pu_spike(i_pu_spike), .i_pu_vmem(i_pu_vmem), .i_pu_ref_ctr(i_pu_ref_ctr),
      .o_spk_valid(o_spk_valid), .i_spk_ready(i_spk_ready), .o_spk_id(o_spk_id), .o_spk_ts(o_spk_ts)
`ifdef NEURON_TDM_SCHED_SPKCNT_EN
      , .o_spk_count(o_spk_count)
`endif
   );

   // LIF rule: refractory holds vmem and counts down; otherwise leak toward 0, integrate, fire at threshold
   function automatic logic [19:0] lif(input int v, input int r, input int syn);
      int lv, nv;
      if (r > 0) return {1'b0, 16'(v), 3'(r - 1)};
      if (v > LEAK) lv = v - LEAK;
      else if (v < -LEAK) lv = v + LEAK;
      else lv = 0;
      nv = lv + syn;
      if (nv > 32767) nv = 32767;
      if (nv < -32768) nv = -32768;
      if (nv >= THRESH) return {1'b1, 16'd0, 3'(REFP)};
      return {1'b0, 16'(nv), 3'd0};
   endfunction

   // PU with one cycle latency; drives junk when idle
   logic [19:0] pu_res;
   always_comb pu_res = lif(int'($signed(o_pu_vmem)), int'(o_pu_ref_ctr), int'($signed(o_pu_syn)));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_pu_spike   <= 1'b0;
         i_pu_vmem    <= 16'd0;
         i_pu_ref_ctr <= 3'd0;
      end else if (o_pu_valid) begin
         i_pu_spike   <= pu_res[19];
         i_pu_vmem    <= pu_res[18:3];
         i_pu_ref_ctr <= pu_res[2:0];
      end else begin
         i_pu_spike   <= 1'($urandom);
         i_pu_vmem    <= 16'($urandom);
         i_pu_ref_ctr <= 3'($urandom);
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference model state
   int vm[N];
   int rf[N];
   int mts;
   int exp_q[$];
   int cur[N];
   int got_v[N];
   int got_r[N];
   int step_spk;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         vm[i] = 0;
         rf[i] = 0;
      end
      mts = 0;
      exp_q.delete();
   endtask

   task automatic check_pop();
      int e;
      if (exp_q.size() == 0) begin
         chk("spk_extra", int'(o_spk_valid), 0);
      end else begin
         e = exp_q.pop_front();
         chk("spk_id", int'(o_spk_id), e >> 16);
         chk("spk_ts", int'(o_spk_ts), e & 32'hFFFF);
      end
   endtask

   task automatic do_reset();
      int cnt;
      rst_n = 1'b0;
      i_step_start = 1'b0;
      i_cur_valid = 1'b0;
      i_spk_ready = 1'b0;
      #1;
      chk("rst_busy", int'(o_busy), 1);
      chk("rst_spk_valid", int'(o_spk_valid), 0);
      chk("rst_timestep", int'(o_timestep), 0);
      chk("rst_step_done", int'(o_step_done), 0);
      chk("rst_pu_valid", int'(o_pu_valid), 0);
      chk("rst_cur_ready", int'(o_cur_ready), 0);
`ifdef NEURON_TDM_SCHED_SPKCNT_EN
      chk("rst_spk_count", int'(o_spk_count), 0);
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      while (o_busy && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      chk("clear_cycles", cnt, N);
      model_reset();
   endtask

   // One timestep: model first, then drive the DUT and compare every issue and every pop
   task automatic run_step(input int gap_pct, input int rdy_pct, input int hold_cyc, input int abort_at);
      int ev[N];
      int er[N];
      int n, cyc;
      bit done;
      logic [19:0] res;
      step_spk = 0;
      for (int i = 0; i < N; i++) begin
         ev[i] = vm[i];
         er[i] = rf[i];
         res = lif(vm[i], rf[i], cur[i]);
         vm[i] = int'($signed(res[18:3]));
         rf[i] = int'(res[2:0]);
         if (res[19]) begin
            exp_q.push_back(i * 65536 + mts);
            step_spk++;
         end
      end
      n = 0;
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 3000) begin
         @(negedge clk);
         if (o_step_done) begin
            done = 1'b1;
            i_step_start = 1'b0;
            i_cur_valid = 1'b0;
            i_spk_ready = 1'b0;
            chk("timestep", int'(o_timestep), (mts + 1) & 32'hFFFF);
            chk("issued", n, N);
`ifdef NEURON_TDM_SCHED_SPKCNT_EN
            chk("spk_count", int'(o_spk_count), step_spk);
`endif
         end else if (abort_at >= 0 && n == abort_at) begin
            i_step_start = 1'b0;
            i_cur_valid = 1'b0;
            i_spk_ready = 1'b0;
            return;
         end else begin
            i_step_start = (cyc == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
            i_cur_valid  = ($urandom_range(0, 99) >= gap_pct);
            i_cur_data   = (n < N) ? 8'(cur[n]) : 8'($urandom);
            i_spk_ready  = (cyc < hold_cyc) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
            #1;
            chk("pu_valid", int'(o_pu_valid), int'(o_cur_ready));
            chk("rdy_wo_valid", int'(o_cur_ready & ~i_cur_valid), 0);
            if (o_cur_ready) begin
               if (n < N) begin
                  chk("vmem", int'(o_pu_vmem), ev[n] & 32'hFFFF);
                  chk("ref", int'(o_pu_ref_ctr), er[n]);
                  chk("syn", int'($signed(o_pu_syn)), cur[n]);
                  got_v[n] = int'($signed(o_pu_vmem));
                  got_r[n] = int'(o_pu_ref_ctr);
               end else begin
                  chk("over_issue", n, N - 1);
               end
               n++;
            end
            if (hold_cyc > 0 && cyc == hold_cyc - 1) begin
               chk("stall_issues", n, 4);
               chk("stall_ready", int'(o_cur_ready), 0);
            end
            if (o_spk_valid && i_spk_ready) check_pop();
         end
         cyc++;
      end
      chk("step_done_seen", int'(done), 1);
      mts = (mts + 1) & 32'hFFFF;
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      i_step_start = 1'b0;
      i_cur_valid = 1'b0;
      while (exp_q.size() > 0 && cyc < 500) begin
         @(negedge clk);
         i_spk_ready = 1'b1;
         #1;
         if (o_spk_valid) check_pop();
         cyc++;
      end
      chk("drain_left", exp_q.size(), 0);
      @(negedge clk);
      i_spk_ready = 1'b0;
      #1;
      chk("fifo_empty", int'(o_spk_valid), 0);
   endtask

   task automatic set_cur(input int val);
      for (int i = 0; i < N; i++) cur[i] = val;
   endtask

   int n5_exp[3] = '{0, 50, 98};

   initial begin
      model_reset();
      do_reset();

      // quiet step: nothing integrates, nothing fires
      set_cur(0);
      run_step(0, 100, 0, -1);
      for (int i = 0; i < N; i++) chk("zero_vmem", got_v[i], 0);
      chk("zero_ts", int'(o_timestep), 1);

      // neuron 3 fires once and counts down; neuron 5 integrates with leak and fires
      for (int s = 0; s < 7; s++) begin
         set_cur(0);
         if (s == 0) cur[3] = 125;
         if (s <= 3) cur[5] = 50;
         run_step(10, 70, 0, -1);
         if (s >= 1) chk("n3_ref", got_r[3], 6 - s);
         if (s <= 2) chk("n5_vmem", got_v[5], n5_exp[s]);
         if (s == 3) begin
            chk("n5_vmem_post", got_v[5], 0);
            chk("n5_ref_post", got_r[5], REFP);
         end
      end
      drain();

      // everyone fires with the stream stalled: throttle must hold issue at FIFO depth
      set_cur(127);
      run_step(0, 100, 40, -1);
      drain();

      // reset in the middle of a step, then a fresh quiet step
      for (int i = 0; i < N; i++) cur[i] = int'($urandom_range(0, 150)) - 20;
      run_step(20, 80, 0, 20);
      do_reset();
      set_cur(0);
      run_step(0, 100, 0, -1);
      for (int i = 0; i < N; i++) chk("post_rst_vmem", got_v[i], 0);

      // random currents, gap-free then gapped
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < N; i++) cur[i] = int'($urandom_range(0, 120)) - 30;
         run_step((k < 5) ? 0 : 30, 60, 0, -1);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/neuron_tdm_sched.md
Name: neuron_tdm_sched

Overview:
- Time-division-multiplexed sequencer that drives one stateless LIF neuron PU across NUM_NEURONS neurons per timestep.
- Owns the per-neuron state memory (vmem, refractory counter) and streams synaptic currents into the PU, one neuron per cycle.
- Writes the PU's registered results back to state memory and emits spike events (neuron id, timestep) on a valid/ready stream to the fan-out/router stage.

Parameters:
NUM_NEURONS, 64, neurons per timestep; must be >= 2
VMEM_WIDTH, 16, membrane potential width (signed)
DATA_WIDTH, 8, synaptic current width (signed)
REF_WIDTH, 3, refractory counter width; matches the PU
V_RESET, 0, vmem value loaded by the clear sweep
TS_WIDTH, 16, timestep counter width
SPK_FIFO_DEPTH, 4, spike event FIFO depth; power of 2, >= 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
i_step_start  in  1  pulse: run one timestep; honoured only in IDLE
o_busy  out  1  high in any state other than IDLE
o_step_done  out  1  one-cycle pulse when the final writeback of the step completes
o_timestep  out  TS_WIDTH  current timestep index
i_cur_valid  in  1  synaptic current valid
o_cur_ready  out  1  current accepted (issued to the PU) this cycle
i_cur_data  in  DATA_WIDTH  signed current for the neuron being issued; neurons arrive in order 0..N-1
o_pu_valid  out  1  to PU i_in_valid
o_pu_vmem  out  VMEM_WIDTH  to PU i_vmem_in
o_pu_ref_ctr  out  REF_WIDTH  to PU i_ref_ctr_in
o_pu_syn  out  DATA_WIDTH  to PU i_syn_current
i_pu_spike  in  1  from PU o_spike
i_pu_vmem  in  VMEM_WIDTH  from PU o_vmem_out
i_pu_ref_ctr  in  REF_WIDTH  from PU o_ref_ctr_out
o_spk_valid  out  1  spike event valid
i_spk_ready  in  1  spike event ready
o_spk_id  out  clog2(NUM_NEURONS)  id of the spiking neuron
o_spk_ts  out  TS_WIDTH  timestep in which the spike occurred

Behaviour:
- FSM states: CLEAR, IDLE, RUN, DRAIN.
- Reset values: state=CLEAR; issue index, o_timestep, FIFO pointers and count, wb_valid all 0; every output 0 except o_busy=1.
- CLEAR: writes vmem=V_RESET and ref=0 to one address per cycle, 0..N-1 (N cycles), then goes to IDLE. The state arrays themselves are not reset by rst_n.
- IDLE: i_step_start sets idx=0 and moves to RUN. A start pulse in any other state is ignored.
- Issue condition (RUN): i_cur_valid && (FIFO free entries - wb_valid) >= 1. When it holds:
  - o_cur_ready=1, o_pu_valid=1.
  - o_pu_vmem/o_pu_ref_ctr are the combinational reads of mem[idx]; o_pu_syn=i_cur_data.
  - wb_idx<=idx, wb_valid<=1, idx++.
- When the issue condition fails, o_pu_valid=0 and no state changes (the issue stalls).
- Issuing idx=N-1 moves the FSM to DRAIN.
- Writeback, 1 cycle after issue (PU latency 1): when wb_valid=1, mem[wb_idx]<={i_pu_vmem, i_pu_ref_ctr}.
  - If i_pu_spike=1, push {wb_idx, o_timestep} into the FIFO.
  - i_pu_spike is ignored whenever wb_valid=0.
- Read/write hazard: the read at idx and the write at wb_idx in the same cycle are always different addresses (N >= 2, strictly in-order issue), so no forwarding is needed.
- DRAIN: on the cycle the final writeback completes, pulse o_step_done, increment o_timestep (wrapping modulo 2^TS_WIDTH), go to IDLE.
- Step completion does not wait for the FIFO to empty; queued spikes keep their own timestep stamp.
- Spike FIFO:
  - Output head is presented on o_spk_*; pop on o_spk_valid && i_spk_ready.
  - Push and pop in the same cycle is legal and leaves the count unchanged.
  - The issue throttle guarantees the FIFO never overflows, so no spike is ever dropped.
- Event ordering: spikes within a step come out in ascending neuron id; steps come out in order.
- Reset mid-operation: the FSM returns to CLEAR, the FIFO is flushed, o_timestep=0, and any in-flight writeback is discarded.

Optional Feature:
- Macro: NEURON_TDM_SCHED_SPKCNT_EN.
- Defined:
  - Adds output o_spk_count [clog2(NUM_NEURONS):0].
  - A counter clears on step start, increments on each accepted PU spike, and is latched into o_spk_count at o_step_done.
  - o_spk_count resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Connect a LIF PU configured with V_THRESH=120, LEAK_VAL=2, REFRACTORY_PERIOD=5.
- Reset release -> o_busy=1 for 64 cycles, then 0. Run one step with all currents 0 -> every o_pu_vmem=0, no o_spk_valid, one o_step_done pulse, o_timestep=1.
- Step 0, neuron 3 current 125, others 0 -> event (id=3, ts=0). Neuron 3's o_pu_ref_ctr reads 5, 4, 3, 2, 1, 0 in steps 1..6, with no spike from it during those steps.
- Neuron 5 current 50 every step -> o_pu_vmem reads 0, 50, 98 in steps 0-2; spike (id=5, ts=2); step 3 reads vmem 0, ref 5.
- i_spk_ready=0 and all currents 127 -> FIFO holds 4, o_cur_ready drops and stays 0. Raise ready -> ids 0..63 come out in order, none lost, o_step_done follows the final writeback.
- i_cur_valid with random gaps versus gap-free with identical currents -> identical spike stream and identical final vmem for all neurons.
- Assert rst_n low mid-step at idx=20 -> o_spk_valid=0, o_timestep=0, 64-cycle clear sweep; the next step matches the fresh-reset result.
- With NEURON_TDM_SCHED_SPKCNT_EN defined: 3 neurons at current 125 -> o_spk_count=3 at o_step_done.
